// File: rtl/frame_buff_wr_ctrl_if.sv
// Write-side bundle of the frame_buff controller: requests, pixel stream and RAM port A.
// master drives the requests and pixels; slave is the controller that drives the RAM port.
interface frame_buff_wr_ctrl_if #(
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 12
);
    logic                     i_arm;
    logic                     i_cont;
    logic                     i_clear;
    logic [c_nb_buf-1:0]      i_clr_val;
    logic                     i_pxl_vld;
    logic                     i_sof;
    logic [c_nb_buf-1:0]      i_pxl;
    logic                     o_wea;
    logic [c_nb_img_pxls-1:0] o_addra;
    logic [c_nb_buf-1:0]      o_dina;
    logic                     o_busy;
    logic                     o_frame_done;
    logic                     o_clr_done;
    logic                     o_err_short;

    modport master (
        output i_arm, i_cont, i_clear, i_clr_val, i_pxl_vld, i_sof, i_pxl,
        input  o_wea, o_addra, o_dina, o_busy, o_frame_done, o_clr_done, o_err_short
    );

    modport slave (
        input  i_arm, i_cont, i_clear, i_clr_val, i_pxl_vld, i_sof, i_pxl,
        output o_wea, o_addra, o_dina, o_busy, o_frame_done, o_clr_done, o_err_short
    );
endinterface

// File: rtl/frame_buff_wr_ctrl.sv
// Write-port sequencer for frame_buff: captures one raster frame from a pixel stream,
// or fills the whole buffer with a constant. All RAM-side outputs are registered.
module frame_buff_wr_ctrl #(
    parameter int c_img_cols    = 80,
    parameter int c_img_rows    = 60,
    parameter int c_img_pxls    = c_img_cols * c_img_rows,
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    frame_buff_wr_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CLEAR, WAIT_SOF, CAPTURE} state_t;

    localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_img_pxls - 1);
    localparam logic [c_nb_img_pxls-1:0] c_one       = c_nb_img_pxls'(1);

    state_t                   state, state_nx;
    logic [c_nb_img_pxls-1:0] cnt, cnt_nx;
    logic [c_nb_buf-1:0]      clr_val, clr_val_nx;

    logic                     wea_p1, wea_nx;
    logic [c_nb_img_pxls-1:0] addra_p1, addra_nx;
    logic [c_nb_buf-1:0]      dina_p1, dina_nx;
    logic                     frame_done_p1, frame_done_nx;
    logic                     clr_done_p1, clr_done_nx;
    logic                     err_short_p1, err_short_nx;

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        clr_val_nx    = clr_val;
        wea_nx        = 1'b0;
        addra_nx      = addra_p1;
        dina_nx       = dina_p1;
        frame_done_nx = 1'b0;
        clr_done_nx   = 1'b0;
        err_short_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.i_clear) begin
                    state_nx   = CLEAR;
                    cnt_nx     = '0;
                    clr_val_nx = bus.i_clr_val;
                end else if (bus.i_arm) begin
                    state_nx = WAIT_SOF;
                end
            end

            CLEAR: begin
                wea_nx   = 1'b1;
                addra_nx = cnt;
                dina_nx  = clr_val;
                if (cnt == c_last_addr) begin
                    clr_done_nx = 1'b1;
                    cnt_nx      = '0;
                    state_nx    = IDLE;
                end else begin
                    cnt_nx = cnt + c_one;
                end
            end

            WAIT_SOF: begin
                // Anything before the first SOF is mid-frame junk and is dropped.
                if (bus.i_pxl_vld && bus.i_sof) begin
                    wea_nx   = 1'b1;
                    addra_nx = '0;
                    dina_nx  = bus.i_pxl;
                    cnt_nx   = c_one;
                    state_nx = CAPTURE;
                end
            end

            CAPTURE: begin
                if (bus.i_pxl_vld) begin
                    wea_nx  = 1'b1;
                    dina_nx = bus.i_pxl;
                    if (bus.i_sof) begin
                        // A fresh SOF before the frame filled: resync onto the new frame.
                        err_short_nx = 1'b1;
                        addra_nx     = '0;
                        cnt_nx       = c_one;
                    end else begin
                        addra_nx = cnt;
                        if (cnt == c_last_addr) begin
                            frame_done_nx = 1'b1;
                            cnt_nx        = '0;
                            state_nx      = bus.i_cont ? WAIT_SOF : IDLE;
                        end else begin
                            cnt_nx = cnt + c_one;
                        end
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            wea_p1        <= 1'b0;
            addra_p1      <= '0;
            dina_p1       <= '0;
            frame_done_p1 <= 1'b0;
            clr_done_p1   <= 1'b0;
            err_short_p1  <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            wea_p1        <= wea_nx;
            addra_p1      <= addra_nx;
            dina_p1       <= dina_nx;
            frame_done_p1 <= frame_done_nx;
            clr_done_p1   <= clr_done_nx;
            err_short_p1  <= err_short_nx;
        end
    end

    // Clear value is only consumed in CLEAR, which always reloads it on entry.
    always_ff @(posedge clk) begin
        clr_val <= clr_val_nx;
    end

    assign bus.o_wea        = wea_p1;
    assign bus.o_addra      = addra_p1;
    assign bus.o_dina       = dina_p1;
    assign bus.o_frame_done = frame_done_p1;
    assign bus.o_clr_done   = clr_done_p1;
    assign bus.o_err_short  = err_short_p1;
    assign bus.o_busy       = (state != IDLE);

endmodule

// File: tb/tb_frame_buff_wr_ctrl.sv
// Bench for frame_buff_wr_ctrl: every RAM write and pulse is logged and compared with the
// write list each scenario expects from the pixels it sent.
module tb_frame_buff_wr_ctrl;

    localparam int PX = 4800;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    frame_buff_wr_ctrl_if bus ();

    frame_buff_wr_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic        w;
        logic [12:0] a;
        logic [11:0] d;
        logic        fd;
        logic        cd;
        logic        es;
    } ev_t;

    ev_t evq[$];
    ev_t expq[$];

    always @(negedge clk)
        if (bus.o_wea === 1'b1 || bus.o_frame_done === 1'b1 ||
            bus.o_clr_done === 1'b1 || bus.o_err_short === 1'b1)
            evq.push_back(ev_t'{cyc, bus.o_wea, bus.o_addra, bus.o_dina,
                                bus.o_frame_done, bus.o_clr_done, bus.o_err_short});

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic string ev_str(ev_t e);
        return $sformatf("c=%0d w=%b a=%0d d=%h fd=%b cd=%b es=%b", e.c, e.w, e.a, e.d, e.fd, e.cd, e.es);
    endfunction

    function automatic string got_at(int i);
        if (i < 0 || i >= evq.size()) return "none";
        return ev_str(evq[i]);
    endfunction

    function automatic string exp_at(int i);
        if (i < 0 || i >= expq.size()) return "none";
        return ev_str(expq[i]);
    endfunction

    // Number of positions where the logged writes differ from the expected list.
    function automatic int diff_events(output int first);
        int n;
        int m;
        bit bad;
        n = 0;
        first = -1;
        m = (evq.size() > expq.size()) ? evq.size() : expq.size();
        for (int i = 0; i < m; i++) begin
            if (i >= evq.size() || i >= expq.size()) bad = 1'b1;
            else bad = (expq[i].c >= 0 && evq[i].c != expq[i].c) || evq[i].w !== 1'b1 ||
                       evq[i].a !== expq[i].a || evq[i].d !== expq[i].d ||
                       evq[i].fd !== expq[i].fd || evq[i].cd !== expq[i].cd ||
                       evq[i].es !== expq[i].es;
            if (bad) begin
                n++;
                if (first < 0) first = i;
            end
        end
        return n;
    endfunction

    task automatic arm();
        bus.i_arm = 1'b1;
        tick();
        bus.i_arm = 1'b0;
    endtask

    task automatic gaps();
        if ($urandom_range(0, 3) == 0) begin
            int n;
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                bus.i_pxl_vld = 1'b0;
                bus.i_sof     = 1'($urandom);
                bus.i_pxl     = 12'($urandom);
                tick();
            end
        end
    endtask

    task automatic pix(input logic s, input logic [11:0] d, output int c);
        bus.i_pxl_vld = 1'b1;
        bus.i_sof     = s;
        bus.i_pxl     = d;
        c = cyc;
        tick();
        bus.i_pxl_vld = 1'b0;
        bus.i_sof     = 1'b0;
    endtask

    // Sends n pixels that should land at a0.. and records the write each must produce
    // one cycle after it is sampled.
    task automatic send_run(input int n, input int a0, input bit sof0, input bit err0,
                            input bit done_last, input bit idx_data);
        int c;
        logic [11:0] d;
        for (int i = 0; i < n; i++) begin
            gaps();
            d = idx_data ? 12'(a0 + i) : 12'($urandom);
            pix(sof0 && i == 0, d, c);
            expq.push_back(ev_t'{c + 1, 1'b1, 13'(a0 + i), d,
                                 done_last && (i == n - 1), 1'b0, err0 && (i == 0)});
        end
    endtask

    task automatic test_reset();
        logic [29:0] v;
        bus.i_arm = 1'b1; bus.i_cont = 1'b0; bus.i_clear = 1'b0; bus.i_clr_val = 12'h0;
        bus.i_pxl_vld = 1'b1; bus.i_sof = 1'b1; bus.i_pxl = 12'hFFF;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            v = {bus.o_wea, bus.o_addra, bus.o_dina, bus.o_busy,
                 bus.o_frame_done, bus.o_clr_done, bus.o_err_short};
            n_checks++;
            if (v !== 30'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h, required 0", k, v);
            end
        end
        bus.i_arm = 1'b0; bus.i_pxl_vld = 1'b0; bus.i_sof = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.o_busy !== 1'b0 || bus.o_wea !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b wea=%b, required 0 0", bus.o_busy, bus.o_wea);
        end
    endtask

    task automatic test_clear();
        int k;
        int d;
        int fi;
        int nc;
        int c;
        evq.delete(); expq.delete();
        for (int i = 0; i < PX; i++)
            expq.push_back(ev_t'{-1, 1'b1, 13'(i), 12'hABC, 1'b0, (i == PX - 1), 1'b0});
        // Clear and arm together: clear must win.
        bus.i_clear = 1'b1; bus.i_arm = 1'b1; bus.i_clr_val = 12'hABC;
        tick();
        bus.i_clear = 1'b0; bus.i_arm = 1'b0; bus.i_clr_val = 12'h123;
        k = 0;
        while (bus.o_busy === 1'b1 && k < 6000) begin
            bus.i_clear   = (k == 100);
            bus.i_arm     = (k == 100);
            bus.i_clr_val = (k == 100) ? 12'h555 : 12'h123;
            bus.i_pxl_vld = (k >= 200 && k < 210);
            bus.i_sof     = 1'b1;
            bus.i_pxl     = 12'h777;
            tick();
            k++;
        end
        bus.i_clear = 1'b0; bus.i_arm = 1'b0; bus.i_pxl_vld = 1'b0; bus.i_sof = 1'b0;
        n_checks++;
        if (k >= 6000) begin
            n_fail++;
            $display("FAIL clear_timeout: busy still %b after %0d cycles, required 0", bus.o_busy, k);
        end
        tick(); tick();
        n_checks++;
        if (evq.size() !== PX) begin
            n_fail++;
            $display("FAIL clear_count: got %0d writes, required %0d", evq.size(), PX);
        end
        d = diff_events(fi);
        n_checks++;
        if (d != 0) begin
            n_fail++;
            $display("FAIL clear_writes: %0d bad entries, first idx %0d got {%s} required {%s}",
                     d, fi, got_at(fi), exp_at(fi));
        end
        nc = 0;
        for (int i = 1; i < evq.size(); i++) if (evq[i].c != evq[0].c + i) nc++;
        n_checks++;
        if (nc != 0) begin
            n_fail++;
            $display("FAIL clear_consecutive: got %0d non-consecutive writes, required 0", nc);
        end
        n_checks++;
        if (bus.o_busy !== 1'b0 || bus.o_addra !== 13'd4799 || bus.o_dina !== 12'hABC) begin
            n_fail++;
            $display("FAIL clear_end_hold: got busy=%b addra=%0d dina=%h, required 0 4799 abc",
                     bus.o_busy, bus.o_addra, bus.o_dina);
        end
        // The arm seen during the clear must not have been queued.
        pix(1'b1, 12'h321, c);
        tick(); tick();
        n_checks++;
        if (evq.size() !== PX || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_no_queue: got %0d writes busy=%b, required %0d writes busy=0",
                     evq.size(), bus.o_busy, PX);
        end
    endtask

    task automatic test_capture();
        int c;
        int d;
        int fi;
        evq.delete(); expq.delete();
        bus.i_cont = 1'b0;
        arm();
        for (int i = 0; i < 10; i++) pix(1'b0, 12'($urandom), c);
        send_run(PX, 0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick(); tick(); tick();
        n_checks++;
        if (evq.size() !== PX) begin
            n_fail++;
            $display("FAIL capture_count: got %0d writes, required %0d", evq.size(), PX);
        end
        d = diff_events(fi);
        n_checks++;
        if (d != 0) begin
            n_fail++;
            $display("FAIL capture_writes: %0d bad entries, first idx %0d got {%s} required {%s}",
                     d, fi, got_at(fi), exp_at(fi));
        end
        n_checks++;
        if (bus.o_busy !== 1'b0 || bus.o_addra !== 13'd4799) begin
            n_fail++;
            $display("FAIL capture_end_idle: got busy=%b addra=%0d, required 0 4799", bus.o_busy, bus.o_addra);
        end
        pix(1'b1, 12'h0AA, c);
        pix(1'b0, 12'h0BB, c);
        tick(); tick();
        n_checks++;
        if (evq.size() !== PX) begin
            n_fail++;
            $display("FAIL capture_idle_ignores: got %0d writes, required %0d", evq.size(), PX);
        end
    endtask

    task automatic test_short_frame();
        int d;
        int fi;
        evq.delete(); expq.delete();
        bus.i_cont = 1'b0;
        arm();
        send_run(101, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_run(PX, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(); tick(); tick();
        n_checks++;
        if (evq.size() !== PX + 101) begin
            n_fail++;
            $display("FAIL short_count: got %0d writes, required %0d", evq.size(), PX + 101);
        end
        d = diff_events(fi);
        n_checks++;
        if (d != 0) begin
            n_fail++;
            $display("FAIL short_writes: %0d bad entries, first idx %0d got {%s} required {%s}",
                     d, fi, got_at(fi), exp_at(fi));
        end
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL short_end_idle: got busy=%b, required 0", bus.o_busy);
        end
    endtask

    task automatic test_continuous();
        int d;
        int fi;
        evq.delete(); expq.delete();
        bus.i_cont = 1'b1;
        arm();
        send_run(PX, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        n_checks++;
        if (bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_rearmed: got busy=%b after frame 1, required 1", bus.o_busy);
        end
        send_run(2000, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.i_clear = 1'b1; bus.i_clr_val = 12'h0F0;
        tick();
        bus.i_clear = 1'b0;
        send_run(PX - 2000, 2000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); tick(); tick();
        n_checks++;
        if (evq.size() !== 2 * PX) begin
            n_fail++;
            $display("FAIL cont_count: got %0d writes, required %0d", evq.size(), 2 * PX);
        end
        d = diff_events(fi);
        n_checks++;
        if (d != 0) begin
            n_fail++;
            $display("FAIL cont_writes: %0d bad entries, first idx %0d got {%s} required {%s}",
                     d, fi, got_at(fi), exp_at(fi));
        end
        n_checks++;
        if (bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_still_waiting: got busy=%b, required 1", bus.o_busy);
        end
    endtask

    task automatic test_reset_midop();
        int d;
        int fi;
        evq.delete(); expq.delete();
        bus.i_cont = 1'b0;
        arm();
        send_run(2000, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        bus.i_pxl_vld = 1'b1; bus.i_sof = 1'b1; bus.i_arm = 1'b1;
        tick();
        n_checks++;
        if (bus.o_busy !== 1'b0 || bus.o_wea !== 1'b0 || bus.o_addra !== 13'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b wea=%b addra=%0d, required 0 0 0",
                     bus.o_busy, bus.o_wea, bus.o_addra);
        end
        tick();
        rst_n = 1'b1;
        bus.i_pxl_vld = 1'b0; bus.i_sof = 1'b0; bus.i_arm = 1'b0;
        tick(); tick();
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: got busy=%b, required 0", bus.o_busy);
        end
        arm();
        send_run(PX, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(); tick(); tick();
        n_checks++;
        if (evq.size() !== 2000 + PX) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d writes, required %0d", evq.size(), 2000 + PX);
        end
        d = diff_events(fi);
        n_checks++;
        if (d != 0) begin
            n_fail++;
            $display("FAIL midreset_writes: %0d bad entries, first idx %0d got {%s} required {%s}",
                     d, fi, got_at(fi), exp_at(fi));
        end
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_end_idle: got busy=%b, required 0", bus.o_busy);
        end
    endtask

    initial begin
        bus.i_arm = 1'b0; bus.i_cont = 1'b0; bus.i_clear = 1'b0; bus.i_clr_val = 12'h0;
        bus.i_pxl_vld = 1'b0; bus.i_sof = 1'b0; bus.i_pxl = 12'h0;
        test_reset();
        test_clear();
        test_capture();
        test_short_frame();
        test_continuous();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
